// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Data-memory access controller between the execute/memory stage and the
//   data-memory bus. Each access is checked for alignment and then run as one
//   req/ack bus transaction. The bus sees a word-aligned address, byte lane
//   enables and lane-replicated write data. Load data comes back right-aligned
//   and zero-padded above the access size; readDataExtend then applies sign
//   extension. The pipeline is stalled for the whole transaction.
//
// Parameters
//   TIMEOUT         BUS-state cycles without ack before abort (1..255)
// Ports
//   i_clk, i_rst_n  clock (rising edge), async active-low reset
//   i_valid         access request; request inputs are held while o_stall=1
//   i_write         1 = store, 0 = load
//   i_memSize       00 word, 01 half, 1x byte
//   i_isLoadSigned  forwarded to o_isLoadSigned on load completion
//   i_addr          byte address
//   i_writeData     right-aligned store data
//   o_stall         pipeline hold
//   o_done          one-cycle completion pulse
//   o_misaligned    with o_done: rejected, no bus cycle was issued
//   o_timeout       with o_done: bus never acknowledged
//   o_readData      right-aligned, zero-padded load data
//   o_memSize       registered size for readDataExtend
//   o_isLoadSigned  registered signedness for readDataExtend
//   o_busReq        bus request
//   o_busWrite      bus write
//   o_busAddr       word address, bits [1:0] = 0
//   o_busByteEn     byte lane enables, bit n = byte n
//   o_busWdata      lane-replicated write data
//   i_busAck        bus completion, meaningful only while o_busReq=1
//   i_busRdata      bus read data, sampled with i_busAck
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic        i_write,
  input  logic [1:0]  i_memSize,
  input  logic        i_isLoadSigned,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_writeData,
  output logic        o_stall,
  output logic        o_done,
  output logic        o_misaligned,
  output logic        o_timeout,
  output logic [31:0] o_readData,
  output logic [1:0]  o_memSize,
  output logic        o_isLoadSigned,
  output logic        o_busReq,
  output logic        o_busWrite,
  output logic [31:0] o_busAddr,
  output logic [3:0]  o_busByteEn,
  output logic [31:0] o_busWdata,
  input  logic        i_busAck,
  input  logic [31:0] i_busRdata
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cnt;

  logic        r_reqWrite;
  logic [1:0]  r_reqSize;
  logic [1:0]  r_reqLane;
  logic        r_reqSigned;

  logic        r_busReq;
  logic        r_busWrite;
  logic [31:0] r_busAddr;
  logic [3:0]  r_busByteEn;
  logic [31:0] r_busWdata;
  logic        r_misaligned;
  logic        r_timeout;
  logic [31:0] r_readData;
  logic [1:0]  r_memSize;
  logic        r_isLoadSigned;

  logic        w_misaligned;
  logic        w_expire;
  logic [3:0]  w_byteEn;
  logic [31:0] w_wdata;
  logic [31:0] w_shifted;
  logic [31:0] w_loadData;

  always_comb begin
    w_misaligned = 1'b0;
    w_byteEn     = 4'b0001 << i_addr[1:0];
    w_wdata      = {4{i_writeData[7:0]}};
    case (i_memSize)
      2'b00: begin
        w_misaligned = |i_addr[1:0];
        w_byteEn     = 4'b1111;
        w_wdata      = i_writeData;
      end
      2'b01: begin
        w_misaligned = i_addr[0];
        w_byteEn     = 4'b0011 << i_addr[1:0];
        w_wdata      = {2{i_writeData[15:0]}};
      end
      default: ;
    endcase
  end

  // Move the addressed lane down to bit 0, then drop bytes above the size.
  assign w_shifted = i_busRdata >> {r_reqLane, 3'b000};

  always_comb begin
    w_loadData = {24'd0, w_shifted[7:0]};
    case (r_reqSize)
      2'b00:   w_loadData = w_shifted;
      2'b01:   w_loadData = {16'd0, w_shifted[15:0]};
      default: ;
    endcase
  end

  // An ack in the last counted cycle takes precedence over expiry.
  assign w_expire = (r_state == S_BUS) && !i_busAck && (r_cnt == TIMEOUT_M1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_valid) w_next = w_misaligned ? S_RESP : S_BUS;
      S_BUS:  if (i_busAck || w_expire) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt          <= '0;
      r_reqWrite     <= 1'b0;
      r_reqSize      <= '0;
      r_reqLane      <= '0;
      r_reqSigned    <= 1'b0;
      r_busReq       <= 1'b0;
      r_busWrite     <= 1'b0;
      r_busAddr      <= '0;
      r_busByteEn    <= '0;
      r_busWdata     <= '0;
      r_misaligned   <= 1'b0;
      r_timeout      <= 1'b0;
      r_readData     <= '0;
      r_memSize      <= '0;
      r_isLoadSigned <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            r_reqWrite  <= i_write;
            r_reqSize   <= i_memSize;
            r_reqLane   <= i_addr[1:0];
            r_reqSigned <= i_isLoadSigned;
            r_cnt       <= '0;
            if (w_misaligned) begin
              r_misaligned <= 1'b1;
              if (!i_write) begin
                r_readData     <= '0;
                r_memSize      <= i_memSize;
                r_isLoadSigned <= i_isLoadSigned;
              end
            end else begin
              r_busReq    <= 1'b1;
              r_busWrite  <= i_write;
              r_busAddr   <= {i_addr[31:2], 2'b00};
              r_busByteEn <= w_byteEn;
              r_busWdata  <= w_wdata;
            end
          end
        end
        S_BUS: begin
          r_cnt <= r_cnt + 8'd1;
          if (i_busAck || w_expire) begin
            r_busReq    <= 1'b0;
            r_busWrite  <= 1'b0;
            r_busByteEn <= '0;
            r_timeout   <= !i_busAck;
            if (!r_reqWrite) begin
              r_readData     <= i_busAck ? w_loadData : '0;
              r_memSize      <= r_reqSize;
              r_isLoadSigned <= r_reqSigned;
            end
          end
        end
        S_RESP: begin
          r_misaligned <= 1'b0;
          r_timeout    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Gated by reset so the stall output is also 0 while reset is asserted.
  assign o_stall        = i_rst_n && ((r_state == S_BUS) || ((r_state == S_IDLE) && i_valid));
  assign o_done         = (r_state == S_RESP);
  assign o_misaligned   = r_misaligned;
  assign o_timeout      = r_timeout;
  assign o_readData     = r_readData;
  assign o_memSize      = r_memSize;
  assign o_isLoadSigned = r_isLoadSigned;
  assign o_busReq       = r_busReq;
  assign o_busWrite     = r_busWrite;
  assign o_busAddr      = r_busAddr;
  assign o_busByteEn    = r_busByteEn;
  assign o_busWdata     = r_busWdata;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        i_write;
  logic [1:0]  i_memSize;
  logic        i_isLoadSigned;
  logic [31:0] i_addr;
  logic [31:0] i_writeData;
  logic        o_stall;
  logic        o_done;
  logic        o_misaligned;
  logic        o_timeout;
  logic [31:0] o_readData;
  logic [1:0]  o_memSize;
  logic        o_isLoadSigned;
  logic        o_busReq;
  logic        o_busWrite;
  logic [31:0] o_busAddr;
  logic [3:0]  o_busByteEn;
  logic [31:0] o_busWdata;
  logic        i_busAck;
  logic [31:0] i_busRdata;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_write(i_write),
    .i_memSize(i_memSize), .i_isLoadSigned(i_isLoadSigned), .i_addr(i_addr),
    .i_writeData(i_writeData), .o_stall(o_stall), .o_done(o_done),
    .o_misaligned(o_misaligned), .o_timeout(o_timeout), .o_readData(o_readData),
    .o_memSize(o_memSize), .o_isLoadSigned(o_isLoadSigned), .o_busReq(o_busReq),
    .o_busWrite(o_busWrite), .o_busAddr(o_busAddr), .o_busByteEn(o_busByteEn),
    .o_busWdata(o_busWdata), .i_busAck(i_busAck), .i_busRdata(i_busRdata)
  );

  always #5 i_clk = ~i_clk;

  // Observations collected by run_txn (cycle 0 = accept cycle).
  int          obs_done_cyc;
  int          obs_req_cnt;
  logic [7:0]  obs_stall;
  logic [31:0] obs_addr;
  logic [3:0]  obs_be;
  logic [31:0] obs_wdata;
  logic        obs_write;
  logic        obs_mis;
  logic        obs_to;
  logic [31:0] obs_rdata;
  logic [1:0]  obs_size;
  logic        obs_signed;
  logic        obs_done_req;
  logic [3:0]  obs_done_be;

  // Called just after a falling edge; presents a request and follows it to o_done.
  // ack_cyc < 0 means the bus never acknowledges.
  task automatic run_txn(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] ad, input logic [31:0] wd,
                         input int ack_cyc, input logic [31:0] rd);
    i_valid = 1'b1; i_write = wr; i_memSize = sz; i_isLoadSigned = sg;
    i_addr = ad; i_writeData = wd; i_busRdata = rd;
    obs_done_cyc = -1; obs_req_cnt = 0; obs_stall = '0;
    obs_addr = 'x; obs_be = 'x; obs_wdata = 'x; obs_write = 'x;
    for (int c = 0; c < 8; c++) begin
      i_busAck = (c == ack_cyc);
      #1;
      obs_stall[c] = o_stall;
      if (o_busReq === 1'b1) begin
        if (obs_req_cnt == 0) begin
          obs_addr = o_busAddr; obs_be = o_busByteEn;
          obs_wdata = o_busWdata; obs_write = o_busWrite;
        end
        obs_req_cnt++;
      end
      if (o_done === 1'b1) begin
        obs_done_cyc = c; obs_mis = o_misaligned; obs_to = o_timeout;
        obs_rdata = o_readData; obs_size = o_memSize; obs_signed = o_isLoadSigned;
        obs_done_req = o_busReq; obs_done_be = o_busByteEn;
        break;
      end
      @(negedge i_clk);
    end
    i_busAck = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic idle();
    i_valid = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_valid = 1'b0; i_write = 1'b0; i_memSize = 2'b00;
    i_isLoadSigned = 1'b0; i_addr = '0; i_writeData = '0; i_busAck = 1'b0; i_busRdata = '0;
    repeat (2) @(negedge i_clk);
    #1;
    n_cmp++; if ({o_stall, o_done, o_misaligned, o_timeout, o_busReq, o_busWrite} !== 6'b0) begin n_fail++; $display("FAIL reset_flags got %b exp 000000", {o_stall, o_done, o_misaligned, o_timeout, o_busReq, o_busWrite}); end
    n_cmp++; if ({o_readData, o_busAddr, o_busWdata} !== 96'b0) begin n_fail++; $display("FAIL reset_data got %h %h %h exp 0", o_readData, o_busAddr, o_busWdata); end
    n_cmp++; if ({o_busByteEn, o_memSize, o_isLoadSigned} !== 7'b0) begin n_fail++; $display("FAIL reset_misc got %b exp 0000000", {o_busByteEn, o_memSize, o_isLoadSigned}); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_load_word();
    run_txn(1'b0, 2'b00, 1'b0, 32'h0000_0100, 32'h0, 3, 32'h8080_1234);
    n_cmp++; if (obs_addr !== 32'h100) begin n_fail++; $display("FAIL lw_addr got %h exp 00000100", obs_addr); end
    n_cmp++; if (obs_be !== 4'b1111) begin n_fail++; $display("FAIL lw_be got %b exp 1111", obs_be); end
    n_cmp++; if (obs_write !== 1'b0) begin n_fail++; $display("FAIL lw_buswrite got %b exp 0", obs_write); end
    n_cmp++; if (obs_done_cyc !== 4) begin n_fail++; $display("FAIL lw_done_cycle got %0d exp 4", obs_done_cyc); end
    n_cmp++; if (obs_rdata !== 32'h8080_1234) begin n_fail++; $display("FAIL lw_rdata got %h exp 80801234", obs_rdata); end
    n_cmp++; if (obs_stall[4:0] !== 5'b01111) begin n_fail++; $display("FAIL lw_stall got %b exp 01111", obs_stall[4:0]); end
    n_cmp++; if (obs_req_cnt !== 3) begin n_fail++; $display("FAIL lw_req_cycles got %0d exp 3", obs_req_cnt); end
    n_cmp++; if ({obs_done_req, obs_done_be, obs_mis, obs_to} !== 7'b0) begin n_fail++; $display("FAIL lw_resp_bus got %b exp 0000000", {obs_done_req, obs_done_be, obs_mis, obs_to}); end
    idle();
  endtask

  task automatic test_load_byte_signed();
    run_txn(1'b0, 2'b10, 1'b1, 32'h0000_0103, 32'h0, 1, 32'h8000_0000);
    n_cmp++; if (obs_be !== 4'b1000) begin n_fail++; $display("FAIL lb_be got %b exp 1000", obs_be); end
    n_cmp++; if (obs_addr !== 32'h100) begin n_fail++; $display("FAIL lb_addr got %h exp 00000100", obs_addr); end
    n_cmp++; if (obs_rdata !== 32'h0000_0080) begin n_fail++; $display("FAIL lb_rdata got %h exp 00000080", obs_rdata); end
    n_cmp++; if ({obs_size, obs_signed} !== 3'b101) begin n_fail++; $display("FAIL lb_size_signed got %b exp 101", {obs_size, obs_signed}); end
    n_cmp++; if (obs_done_cyc !== 2) begin n_fail++; $display("FAIL lb_done_cycle got %0d exp 2", obs_done_cyc); end
    idle();
  endtask

  task automatic test_store_half();
    run_txn(1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 1, 32'hFFFF_FFFF);
    n_cmp++; if (obs_be !== 4'b1100) begin n_fail++; $display("FAIL sh_be got %b exp 1100", obs_be); end
    n_cmp++; if (obs_wdata !== 32'hABCD_ABCD) begin n_fail++; $display("FAIL sh_wdata got %h exp abcdabcd", obs_wdata); end
    n_cmp++; if ({obs_write, obs_addr} !== {1'b1, 32'h200}) begin n_fail++; $display("FAIL sh_write_addr got %b %h exp 1 00000200", obs_write, obs_addr); end
    n_cmp++; if (obs_done_cyc !== 2) begin n_fail++; $display("FAIL sh_done_cycle got %0d exp 2", obs_done_cyc); end
    n_cmp++; if ({obs_rdata, obs_size, obs_signed} !== {32'h80, 2'b10, 1'b1}) begin n_fail++; $display("FAIL sh_load_regs_kept got %h %b %b exp 00000080 10 1", obs_rdata, obs_size, obs_signed); end
    idle();
  endtask

  task automatic test_byte_half_lanes();
    run_txn(1'b1, 2'b11, 1'b0, 32'h0000_0001, 32'h0000_0055, 2, 32'h0);
    n_cmp++; if ({obs_be, obs_wdata} !== {4'b0010, 32'h5555_5555}) begin n_fail++; $display("FAIL sb_lane got %b %h exp 0010 55555555", obs_be, obs_wdata); end
    n_cmp++; if (obs_done_cyc !== 3) begin n_fail++; $display("FAIL sb_done_cycle got %0d exp 3", obs_done_cyc); end
    idle();
    run_txn(1'b0, 2'b01, 1'b0, 32'h0000_0402, 32'h0, 1, 32'hBEEF_1234);
    n_cmp++; if ({obs_be, obs_addr} !== {4'b1100, 32'h400}) begin n_fail++; $display("FAIL lhu_bus got %b %h exp 1100 00000400", obs_be, obs_addr); end
    n_cmp++; if ({obs_rdata, obs_size, obs_signed} !== {32'h0000_BEEF, 2'b01, 1'b0}) begin n_fail++; $display("FAIL lhu_rdata got %h %b %b exp 0000beef 01 0", obs_rdata, obs_size, obs_signed); end
    idle();
  endtask

  task automatic test_misaligned();
    run_txn(1'b0, 2'b00, 1'b0, 32'h0000_0102, 32'h0, -1, 32'h0);
    n_cmp++; if (obs_req_cnt !== 0) begin n_fail++; $display("FAIL lw_mis_req got %0d exp 0", obs_req_cnt); end
    n_cmp++; if ({obs_done_cyc == 1, obs_mis, obs_to} !== 3'b110) begin n_fail++; $display("FAIL lw_mis_done got cyc %0d mis %b to %b exp cyc 1 mis 1 to 0", obs_done_cyc, obs_mis, obs_to); end
    n_cmp++; if (obs_stall[1:0] !== 2'b01) begin n_fail++; $display("FAIL lw_mis_stall got %b exp 01", obs_stall[1:0]); end
    n_cmp++; if ({obs_rdata, obs_size} !== {32'h0, 2'b00}) begin n_fail++; $display("FAIL lw_mis_rdata got %h %b exp 00000000 00", obs_rdata, obs_size); end
    idle();
    run_txn(1'b0, 2'b01, 1'b1, 32'h0000_0101, 32'h0, 1, 32'h0);
    n_cmp++; if ({obs_req_cnt == 0, obs_done_cyc == 1, obs_mis, obs_stall[1]} !== 4'b1110) begin n_fail++; $display("FAIL lh_mis got req %0d cyc %0d mis %b stall %b exp 0 1 1 0", obs_req_cnt, obs_done_cyc, obs_mis, obs_stall[1]); end
    n_cmp++; if ({obs_size, obs_signed} !== 3'b011) begin n_fail++; $display("FAIL lh_mis_size got %b exp 011", {obs_size, obs_signed}); end
    idle();
    n_cmp++; if (o_misaligned !== 1'b0) begin n_fail++; $display("FAIL mis_flag_clear got %b exp 0", o_misaligned); end
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 2'b00, 1'b0, 32'h0000_0300, 32'h0, 4, 32'hCAFE_F00D);
    n_cmp++; if ({obs_done_cyc == 5, obs_to} !== 2'b10) begin n_fail++; $display("FAIL late_ack got cyc %0d to %b exp cyc 5 to 0", obs_done_cyc, obs_to); end
    n_cmp++; if (obs_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL late_ack_rdata got %h exp cafef00d", obs_rdata); end
    idle();
    run_txn(1'b0, 2'b00, 1'b0, 32'h0000_0300, 32'h0, -1, 32'hCAFE_F00D);
    n_cmp++; if (obs_req_cnt !== 4) begin n_fail++; $display("FAIL to_req_cycles got %0d exp 4", obs_req_cnt); end
    n_cmp++; if ({obs_done_cyc == 5, obs_to, obs_mis} !== 3'b110) begin n_fail++; $display("FAIL to_done got cyc %0d to %b mis %b exp cyc 5 to 1 mis 0", obs_done_cyc, obs_to, obs_mis); end
    n_cmp++; if (obs_rdata !== 32'h0) begin n_fail++; $display("FAIL to_rdata got %h exp 00000000", obs_rdata); end
    idle();
  endtask

  task automatic test_back_to_back();
    run_txn(1'b1, 2'b00, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1, 32'h0);
    n_cmp++; if ({obs_be, obs_wdata, obs_done_cyc == 2} !== {4'b1111, 32'hDEAD_BEEF, 1'b1}) begin n_fail++; $display("FAIL b2b_sw got %b %h cyc %0d exp 1111 deadbeef cyc 2", obs_be, obs_wdata, obs_done_cyc); end
    run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0012, 32'h0, 1, 32'h00AB_0000);
    n_cmp++; if ({obs_be, obs_rdata, obs_done_cyc == 2} !== {4'b0100, 32'h0000_00AB, 1'b1}) begin n_fail++; $display("FAIL b2b_lbu got %b %h cyc %0d exp 0100 000000ab cyc 2", obs_be, obs_rdata, obs_done_cyc); end
    idle();
  endtask

  task automatic test_reset_mid();
    i_valid = 1'b1; i_write = 1'b0; i_memSize = 2'b00; i_isLoadSigned = 1'b1; i_addr = 32'h100;
    i_busAck = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    n_cmp++; if ({o_busReq, o_stall, o_done, o_busByteEn} !== 7'b0) begin n_fail++; $display("FAIL rst_mid_ctrl got %b exp 0000000", {o_busReq, o_stall, o_done, o_busByteEn}); end
    n_cmp++; if ({o_busAddr, o_readData, o_memSize, o_isLoadSigned} !== 67'b0) begin n_fail++; $display("FAIL rst_mid_data got %h %h %b %b exp 0", o_busAddr, o_readData, o_memSize, o_isLoadSigned); end
    i_valid = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    run_txn(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1, 32'h1122_3344);
    n_cmp++; if ({obs_done_cyc == 2, obs_rdata, obs_addr} !== {1'b1, 32'h1122_3344, 32'h0}) begin n_fail++; $display("FAIL rst_after_lw got cyc %0d %h %h exp cyc 2 11223344 00000000", obs_done_cyc, obs_rdata, obs_addr); end
    idle();
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_byte_signed();
    test_store_half();
    test_byte_half_lanes();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Data-memory access controller between the execute/memory pipeline stage and the data-memory bus. Accepts one load or store per request, checks alignment, drives a req/ack bus transaction with word-aligned address, byte enables and lane-replicated write data, and returns load data right-aligned and zero-padded above the access size. Its load outputs feed `readDataExtend`, which performs sign extension. Stalls the pipeline for the whole transaction.

## Interface
- TIMEOUT, 255, maximum BUS-state cycles without `i_busAck` before abort; legal range 1..255.

- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  pipeline presents an access; held with all request inputs stable while `o_stall`=1
- i_write  in  1  1 = store, 0 = load
- i_memSize  in  2  00 word, 01 half, 10/11 byte
- i_isLoadSigned  in  1  passed through to `o_isLoadSigned`
- i_addr  in  32  byte address
- i_writeData  in  32  store data, right-aligned
- o_stall  out  1  pipeline hold
- o_done  out  1  one-cycle completion pulse
- o_misaligned  out  1  with `o_done`: access rejected, no bus cycle
- o_timeout  out  1  with `o_done`: bus did not ack
- o_readData  out  32  load data, right-aligned, upper bits zero
- o_memSize  out  2  registered copy for `readDataExtend`
- o_isLoadSigned  out  1  registered copy for `readDataExtend`
- o_busReq  out  1  bus request
- o_busWrite  out  1  bus write
- o_busAddr  out  32  word address, bits [1:0] = 0
- o_busByteEn  out  4  lane enables, bit n = byte n
- o_busWdata  out  32  lane-replicated write data
- i_busAck  in  1  bus completion, valid only while `o_busReq`=1
- i_busRdata  in  32  read data, sampled when `i_busAck`=1

## Operation
- FSM states: IDLE, BUS, RESP. Reset state: IDLE.
- IDLE with `i_valid`=1: alignment check. Word requires addr[1:0]=00. Half requires addr[0]=0. Byte is always aligned.
  - Misaligned: latch the misaligned flag and go to RESP. No bus activity.
  - Aligned: register the bus outputs, clear the counter, go to BUS.
- Byte enables:
  - word: 1111
  - half: 0011 << addr[1:0]
  - byte: 0001 << addr[1:0]
- Write data:
  - word: as-is
  - half: {wd[15:0], wd[15:0]}
  - byte: {4{wd[7:0]}}
- BUS: `o_busReq`=1 with all bus outputs held constant. The counter increments each cycle.
  - On `i_busAck`: for a load, capture `i_busRdata >> (8*addr[1:0])` masked to size (half keeps [15:0], byte keeps [7:0]). Go to RESP.
  - If the counter reaches TIMEOUT-1 without an ack: latch timeout, set `o_readData`=0, go to RESP.
  - An ack in the final counted cycle wins over timeout.
- RESP: `o_done`=1 plus the applicable flag for exactly one cycle, then IDLE.
- Load data outputs update only on completion:
  - `o_readData`, `o_memSize` and `o_isLoadSigned` update only on load completion (ack, timeout or misaligned).
  - A store completion leaves them unchanged.
  - Misaligned load: `o_readData`=0.
- `o_stall` = (state==BUS) | (state==IDLE & `i_valid`). It is 0 in RESP, so the pipeline advances at the end of RESP.
- `i_valid` is ignored in RESP. A new request is accepted in the next IDLE cycle.
- `i_busAck` outside BUS is ignored.

## Timing
- Reset values: all outputs 0 (`o_busByteEn`=0000, `o_memSize`=00), counter 0, state IDLE. Assertion of `i_rst_n` clears state and outputs immediately, including mid-transaction. `o_busReq` drops asynchronously.
- Bus outputs are registers, valid from the cycle after acceptance. On exit from BUS, `o_busReq`=0 and `o_busByteEn`=0000.
- Latency: accept in cycle 0, BUS from cycle 1, ack in cycle k, RESP (`o_done`) in cycle k+1.
  - Minimum load/store latency is 2 cycles (ack in cycle 1).
  - A misaligned request gives `o_done` in cycle 1.
- Timeout: `o_busReq` high for exactly TIMEOUT cycles, then RESP.
- Back-to-back requests: the minimum spacing between accepts is 3 cycles (IDLE, BUS, RESP).

## Test plan
- lw addr 0x0000_0100, ack in the 3rd BUS cycle, rdata 0x8080_1234 -> busAddr 0x100, byteEn 1111, busWrite 0, `o_done` in cycle 4, `o_readData` 0x8080_1234, `o_stall` high cycles 0-3.
- lb signed addr 0x103, rdata 0x8000_0000, ack immediately -> byteEn 1000, busAddr 0x100, `o_readData` 0x0000_0080, `o_memSize` 10, `o_isLoadSigned` 1, `o_done` in cycle 2.
- sh addr 0x202, wdata 0x1234_ABCD -> byteEn 1100, busWdata 0xABCD_ABCD, busWrite 1; afterwards `o_readData` is unchanged from the previous load.
- lw addr 0x102 -> `o_busReq` never asserted; `o_done`=1 and `o_misaligned`=1 in cycle 1; `o_stall`=0 in that cycle. lh addr 0x101 behaves the same.
- TIMEOUT=4, no ack -> `o_busReq` high cycles 1-4, RESP in cycle 5 with `o_timeout`=1 and `o_readData`=0. Separately, ack in the 4th BUS cycle -> normal completion with `o_timeout`=0.
- `i_rst_n` pulled low in the 2nd BUS cycle -> `o_busReq`=0 and all outputs 0 immediately. After release, lw addr 0x0 with an immediate ack completes normally in 2 cycles.
